alarm_bank_setter: RTL

Parametrised multi-slot alarm editor and matcher for the digital clock. Holds NUM_ALARMS independent HH:MM alarm slots, each with its own enable bit. Slots are edited digit-by-digit through the shared mode/inc buttons, with correct 24-hour bounds. The block compares every enabled slot against the running clock on each minute boundary and drives the ring output. It sits beside the timekeeping counter and feeds the display mux and buzzer driver.

---
 rtl/alarm_bank_setter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alarm_bank_setter.sv
// rtl/alarm_bank_setter.sv - multi-slot HH:MM alarm editor, matcher and ring controller
module alarm_bank_setter #(
  parameter int NUM_ALARMS   = 4,
  parameter int RING_MINUTES = 5,
  localparam int SLOT_W      = $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_alarm_en,
  input  logic                  mode_button,
  input  logic                  inc_button,
  input  logic                  stop_button,
  input  logic                  minute_tick,
  input  logic [1:0]            cur_hours_left,
  input  logic [3:0]            cur_hours_right,
  input  logic [2:0]            cur_minutes_left,
  input  logic [3:0]            cur_minutes_right,
  output logic [SLOT_W-1:0]     o_slot,
  output logic [1:0]            o_hours_left,
  output logic [3:0]            o_hours_right,
  output logic [2:0]            o_minutes_left,
  output logic [3:0]            o_minutes_right,
  output logic                  o_on_off,
  output logic [NUM_ALARMS-1:0] o_enabled_mask,
  output logic                  ack_flag,
  output logic                  alarm_ring,
  output logic [SLOT_W-1:0]     ring_slot
);

  localparam logic [2:0] SEL   = 3'd0;
  localparam logic [2:0] HL    = 3'd1;
  localparam logic [2:0] HR    = 3'd2;
  localparam logic [2:0] ML    = 3'd3;
  localparam logic [2:0] MR    = 3'd4;
  localparam logic [2:0] ONOFF = 3'd5;

  logic [2:0]            state;
  logic [1:0]            s_hl [NUM_ALARMS];
  logic [3:0]            s_hr [NUM_ALARMS];
  logic [2:0]            s_ml [NUM_ALARMS];
  logic [3:0]            s_mr [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] s_en;
  logic [SLOT_W-1:0]     next_slot;
  logic                  hit;
  logic [SLOT_W-1:0]     hit_idx;
  logic [3:0]            ring_cnt;

  assign o_enabled_mask = s_en;

  // Slot selection wraps at the configured number of slots, not at the power of two.
  always_comb begin
    next_slot = '0;
    if (o_slot != SLOT_W'(NUM_ALARMS - 1)) next_slot = o_slot + 1'b1;
  end

  // Lowest-index enabled committed slot equal to the running time; scanning downward lets low indices win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (s_en[i] && s_hl[i] == cur_hours_left && s_hr[i] == cur_hours_right &&
          s_ml[i] == cur_minutes_left && s_mr[i] == cur_minutes_right) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
    end
  end

  // Edit FSM, edit buffer and committed slot storage; mode wins over inc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= SEL;
      o_slot          <= '0;
      o_hours_left    <= '0;
      o_hours_right   <= '0;
      o_minutes_left  <= '0;
      o_minutes_right <= '0;
      o_on_off        <= 1'b0;
      ack_flag        <= 1'b0;
      s_en            <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        s_hl[i] <= '0;
        s_hr[i] <= '0;
        s_ml[i] <= '0;
        s_mr[i] <= '0;
      end
    end else begin
      ack_flag <= 1'b0;
      if (!set_alarm_en) begin
        state           <= SEL;
        o_hours_left    <= s_hl[o_slot];
        o_hours_right   <= s_hr[o_slot];
        o_minutes_left  <= s_ml[o_slot];
        o_minutes_right <= s_mr[o_slot];
        o_on_off        <= s_en[o_slot];
      end else if (mode_button) begin
        case (state)
          SEL:   state <= HL;
          HL:    state <= HR;
          HR:    state <= ML;
          ML:    state <= MR;
          MR:    state <= ONOFF;
          ONOFF: begin
            s_hl[o_slot] <= o_hours_left;
            s_hr[o_slot] <= o_hours_right;
            s_ml[o_slot] <= o_minutes_left;
            s_mr[o_slot] <= o_minutes_right;
            s_en[o_slot] <= o_on_off;
            ack_flag     <= 1'b1;
            state        <= SEL;
          end
          default: state <= SEL;
        endcase
      end else if (inc_button) begin
        case (state)
          SEL: begin
            o_slot          <= next_slot;
            o_hours_left    <= s_hl[next_slot];
            o_hours_right   <= s_hr[next_slot];
            o_minutes_left  <= s_ml[next_slot];
            o_minutes_right <= s_mr[next_slot];
            o_on_off        <= s_en[next_slot];
          end
          HL: begin
            if (o_hours_left == 2'd2) begin
              o_hours_left <= 2'd0;
            end else begin
              o_hours_left <= o_hours_left + 2'd1;
              // Entering the 20s must not leave an invalid 24..29 hour.
              if (o_hours_left == 2'd1 && o_hours_right > 4'd3) o_hours_right <= 4'd0;
            end
          end
          HR: begin
            if ((o_hours_left == 2'd2 && o_hours_right >= 4'd3) || o_hours_right >= 4'd9)
              o_hours_right <= 4'd0;
            else
              o_hours_right <= o_hours_right + 4'd1;
          end
          ML: o_minutes_left  <= (o_minutes_left >= 3'd5)  ? 3'd0 : o_minutes_left + 3'd1;
          MR: o_minutes_right <= (o_minutes_right >= 4'd9) ? 4'd0 : o_minutes_right + 4'd1;
          ONOFF: o_on_off <= ~o_on_off;
          default: ;
        endcase
      end
    end
  end

  // Ring control: stop beats everything, a running ring counts ticks and never re-triggers on its last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_ring <= 1'b0;
      ring_slot  <= '0;
      ring_cnt   <= '0;
    end else if (stop_button) begin
      alarm_ring <= 1'b0;
    end else if (minute_tick) begin
      if (alarm_ring) begin
        if (ring_cnt == 4'(RING_MINUTES - 1)) begin
          alarm_ring <= 1'b0;
          ring_cnt   <= '0;
        end else begin
          ring_cnt <= ring_cnt + 4'd1;
        end
      end else if (hit) begin
        alarm_ring <= 1'b1;
        ring_slot  <= hit_idx;
        ring_cnt   <= '0;
      end
    end
  end

endmodule
